instr_fetch: RTL

Instruction fetch stage for the multicycle RV32 core; sits directly upstream of `ir_decoder` and produces the 32-bit instruction word on its `ir` input. It holds the program counter and issues one word-aligned read at a time over a valid/ready memory port. It captures each response into an instruction register and presents it to the decoder with a valid/ready handshake. A redirect input (branch, jump, trap) reloads the PC and squashes any in-flight fetch.

---
 rtl/instr_fetch.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage for the multicycle RV32 core.
// Holds the PC, issues one word read at a time over a valid/ready memory
// port, captures the response into the instruction register and hands it
// to the decoder. A redirect reloads the PC and squashes any in-flight fetch.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        mem_req_valid,
    output logic [31:0] mem_req_addr,
    input  logic        mem_req_ready,
    input  logic        mem_rsp_valid,
    input  logic [31:0] mem_rsp_data,
    input  logic        mem_rsp_err,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    output logic        ir_valid,
    output logic [1:0]  ir_fault,
    input  logic        ir_ready
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    localparam logic [1:0] FAULT_NONE   = 2'b00;
    localparam logic [1:0] FAULT_ACCESS = 2'b01;
    localparam logic [1:0] FAULT_ALIGN  = 2'b10;

    state_t      r_state;
    state_t      w_state_next;
    logic [31:0] r_pc;
    logic [31:0] w_pc_next;
    logic [31:0] r_ir;
    logic [31:0] w_ir_next;
    logic [31:0] r_ir_pc;
    logic [31:0] w_ir_pc_next;
    logic [1:0]  r_ir_fault;
    logic [1:0]  w_ir_fault_next;
    logic        r_squash;
    logic        w_squash_next;

    logic        w_misaligned;
    logic        w_req_accept;
    logic        w_in_wait;

    assign w_misaligned = (redirect_pc[1:0] != 2'b00);
    assign w_req_accept = (r_state == ST_REQ) && mem_req_ready;
    assign w_in_wait    = (r_state == ST_WAIT);

    // Outputs come from registered state only; no input reaches them combinationally.
    assign mem_req_valid = (r_state == ST_REQ);
    assign mem_req_addr  = r_pc;
    assign ir_valid      = (r_state == ST_HOLD);
    assign ir            = r_ir;
    assign ir_pc         = r_ir_pc;
    assign ir_fault      = r_ir_fault;

    // State, PC, instruction register and squash flag; async active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_ir       <= 32'h0000_0000;
            r_ir_pc    <= 32'h0000_0000;
            r_ir_fault <= FAULT_NONE;
            r_squash   <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_pc       <= w_pc_next;
            r_ir       <= w_ir_next;
            r_ir_pc    <= w_ir_pc_next;
            r_ir_fault <= w_ir_fault_next;
            r_squash   <= w_squash_next;
        end
    end

    // Next-state and datapath updates; redirect overrides every other transition.
    always_comb begin
        w_state_next    = r_state;
        w_pc_next       = r_pc;
        w_ir_next       = r_ir;
        w_ir_pc_next    = r_ir_pc;
        w_ir_fault_next = r_ir_fault;
        // A pending squash is cleared by the stale response wherever it lands,
        // so a later genuine response is never mistaken for it.
        w_squash_next   = r_squash && !mem_rsp_valid;

        if (redirect_valid) begin
            w_pc_next = redirect_pc;
            // Remember to drop a response that is still owed by memory.
            if (w_req_accept || (w_in_wait && !mem_rsp_valid)) begin
                w_squash_next = 1'b1;
            end else if (w_in_wait) begin
                w_squash_next = 1'b0;
            end

            if (w_misaligned) begin
                // Present the fault directly; nothing is fetched and the PC stays put.
                w_state_next    = ST_HOLD;
                w_ir_next       = 32'h0000_0000;
                w_ir_pc_next    = redirect_pc;
                w_ir_fault_next = FAULT_ALIGN;
            end else if (w_in_wait) begin
                w_state_next = mem_rsp_valid ? ST_REQ : ST_WAIT;
            end else if (w_req_accept) begin
                w_state_next = ST_WAIT;
            end else begin
                w_state_next = ST_REQ;
            end
        end else begin
            case (r_state)
                ST_BOOT: begin
                    w_state_next = ST_REQ;
                end
                ST_REQ: begin
                    if (mem_req_ready) begin
                        w_state_next = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_rsp_valid) begin
                        if (r_squash) begin
                            w_state_next = ST_REQ;
                        end else begin
                            w_state_next    = ST_HOLD;
                            w_ir_pc_next    = r_pc;
                            w_pc_next       = r_pc + 32'd4;
                            w_ir_next       = mem_rsp_err ? 32'h0000_0000 : mem_rsp_data;
                            w_ir_fault_next = mem_rsp_err ? FAULT_ACCESS : FAULT_NONE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (ir_ready) begin
                        w_state_next = ST_REQ;
                    end
                end
                default: begin
                    w_state_next = ST_BOOT;
                end
            endcase
        end
    end

endmodule
